// File: rtl/mas_response_router.sv
// Return path of the memory access servicer tree: an in-order tag FIFO pairs each
// memory response with its requester and holds it one-hot until that requester acks.
module mas_response_router #(
  parameter int unsigned n_outputs  = 8,
  parameter int unsigned data_width = 128,
  parameter int unsigned id_width   = 3,
  parameter int unsigned depth      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [id_width-1:0]   issue_id,
  output logic                  issue_ready,
  input  logic                  resp_valid,
  input  logic [data_width-1:0] resp_data,
  output logic                  resp_ready,
  output logic [n_outputs-1:0]  out_valid,
  output logic [data_width-1:0] out_data,
  input  logic [n_outputs-1:0]  out_ack,
  output logic [id_width:0]     outstanding,
  output logic                  err
);

  localparam int unsigned ptr_w = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned cnt_w = id_width + 1;

  typedef enum logic {
    IDLE,
    DELIVER
  } state_t;

  state_t state;
  state_t state_next;

  logic [id_width-1:0] tag_mem [depth];
  logic [ptr_w-1:0]    wr_ptr;
  logic [ptr_w-1:0]    rd_ptr;

  logic id_ok;
  logic bad_id;
  logic push;
  logic pop;
  logic orphan;
  logic fifo_nonempty;
  logic held_ack;

  // Issue side: full blocks issue regardless of a same-cycle pop (no bypass).
  assign issue_ready   = (outstanding < cnt_w'(depth));
  assign id_ok         = ({1'b0, issue_id} < cnt_w'(n_outputs));
  assign push          = issue_valid && issue_ready && id_ok;
  assign bad_id        = issue_valid && !id_ok;
  assign fifo_nonempty = (outstanding != '0);

  // out_valid is one-hot on the held requester, so masking the acks selects its bit.
  assign held_ack = |(out_ack & out_valid);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and response handshake
  always_comb begin
    state_next = state;
    resp_ready = 1'b0;
    pop        = 1'b0;
    orphan     = 1'b0;
    case (state)
      IDLE: begin
        resp_ready = 1'b1;
        if (resp_valid) begin
          if (fifo_nonempty) begin
            pop        = 1'b1;
            state_next = DELIVER;
          end else begin
            orphan = 1'b1;
          end
        end
      end
      DELIVER: begin
        resp_ready = held_ack;
        if (held_ack) begin
          if (resp_valid && fifo_nonempty) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
            orphan     = resp_valid;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Tag storage needs no reset: entries are only read behind a valid occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= issue_id;
    end
  end

  // Pointers, occupancy, held response and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      out_valid   <= '0;
      out_data    <= '0;
      err         <= 1'b0;
    end else begin
      err <= orphan | bad_id;
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   outstanding <= outstanding + cnt_w'(1);
        2'b01:   outstanding <= outstanding - cnt_w'(1);
        default: outstanding <= outstanding;
      endcase
      if (pop) begin
        out_valid <= n_outputs'(1) << tag_mem[rd_ptr];
        out_data  <= resp_data;
      end else if ((state == DELIVER) && held_ack) begin
        out_valid <= '0;
      end
    end
  end

endmodule
